// File: rtl/sig_menu_ctrl_pkg.sv
// rtl/sig_menu_ctrl_pkg.sv - shared menu encodings, row indices and sizes
package sig_pkg;

    localparam int N_L1  = 3;
    localparam int N_SIG = 5;
    localparam int N_VAL = 4;

    localparam int ROW_WAVE  = 0;
    localparam int ROW_AMP   = 1;
    localparam int ROW_FRE   = 2;
    localparam int ROW_PHASE = 3;
    localparam int ROW_APPLY = 4;

    typedef enum logic [2:0] {
        S_TOP,
        S_SIG,
        S_OSI,
        S_LOA,
        S_COMMIT
    } state_t;

    // Submenu entered by confirm on a given top-level item
    function automatic state_t item_state(input logic [1:0] item);
        case (item)
            2'd0:    return S_SIG;
            2'd1:    return S_OSI;
            2'd2:    return S_LOA;
            default: return S_TOP;
        endcase
    endfunction

endpackage

// File: rtl/sig_menu_ctrl_wrap_cnt.sv
// rtl/sig_menu_ctrl_wrap_cnt.sv - modulo-MAX up/down counter with synchronous load
module wrap_cnt #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX)
) (
    input  logic         clk_50M,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] q
);

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (ld) begin
            q <= ld_val;
        end else if (inc) begin
            q <= (q == W'(MAX - 1)) ? '0 : q + 1'b1;
        end else if (dec) begin
            q <= (q == '0) ? W'(MAX - 1) : q - 1'b1;
        end
    end

endmodule

// File: rtl/sig_menu_ctrl.sv
// rtl/sig_menu_ctrl.sv - menu sequencer with staged/committed waveform config and commit handshake
import sig_pkg::*;

module sig_menu_ctrl #(
    parameter int IDLE_TIMEOUT = 500_000_000,
    parameter int ACK_TIMEOUT  = 1024
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_confirm,
    input  logic       btn_quit,
    input  logic       cfg_ack,
    output logic [1:0] cnt_level1,
    output logic       level,
    output logic [2:0] sel_sig,
    output logic [1:0] stg_wave,
    output logic [1:0] stg_amp,
    output logic [1:0] stg_fre,
    output logic [1:0] stg_phase,
    output logic [1:0] cfg_wave,
    output logic [1:0] cfg_amp,
    output logic [1:0] cfg_fre,
    output logic [1:0] cfg_phase,
    output logic       cfg_req,
    output logic       cfg_active,
    output logic       cfg_err
);

    localparam int L1_W   = $clog2(N_L1);
    localparam int SEL_W  = $clog2(N_SIG);
    localparam int VAL_W  = $clog2(N_VAL);
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT);
    localparam int ACK_W  = $clog2(ACK_TIMEOUT);

    state_t                      state;
    logic [IDLE_W-1:0]           idle_cnt;
    logic [ACK_W-1:0]            ack_cnt;
    logic [3:0][VAL_W-1:0]       stg_q;
    logic [3:0][VAL_W-1:0]       cfg_q;

    logic any_btn, in_menu, idle_to, do_quit, in_sig;
    logic p_conf, p_ud, p_lr, lr_inc, lr_dec, ud_inc, ud_dec, commit_go;

    // One winner per cycle: quit > confirm > up/down > left/right; idle timeout acts as quit
    assign any_btn   = btn_left | btn_right | btn_up | btn_down | btn_confirm | btn_quit;
    assign in_menu   = (state == S_SIG) || (state == S_OSI) || (state == S_LOA);
    assign idle_to   = (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1));
    assign do_quit   = in_menu & (btn_quit | idle_to);
    assign in_sig    = (state == S_SIG) & ~do_quit;
    assign p_conf    = ~btn_quit & btn_confirm;
    assign p_ud      = ~btn_quit & ~btn_confirm & (btn_up | btn_down);
    assign p_lr      = ~btn_quit & ~btn_confirm & ~btn_up & ~btn_down & (btn_left | btn_right);
    assign lr_dec    = p_lr & btn_left;
    assign lr_inc    = p_lr & ~btn_left;
    assign ud_dec    = p_ud & btn_up;
    assign ud_inc    = p_ud & ~btn_up;
    assign commit_go = in_sig & p_conf & (sel_sig == SEL_W'(ROW_APPLY));

    wrap_cnt #(.MAX(N_L1)) u_level1 (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .inc     ((state == S_TOP) & lr_inc),
        .dec     ((state == S_TOP) & lr_dec),
        .ld      (1'b0),
        .ld_val  ({L1_W{1'b0}}),
        .q       (cnt_level1)
    );

    wrap_cnt #(.MAX(N_SIG)) u_sel (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .inc     (in_sig & ud_inc),
        .dec     (in_sig & ud_dec),
        .ld      (do_quit),
        .ld_val  ({SEL_W{1'b0}}),
        .q       (sel_sig)
    );

    // Leaving a menu reloads the staged rows from the committed set
    for (genvar r = 0; r < 4; r++) begin : g_stg
        logic row_hit;
        assign row_hit = (sel_sig == SEL_W'(r));
        wrap_cnt #(.MAX(N_VAL)) u_stg (
            .clk_50M (clk_50M),
            .rst_n   (rst_n),
            .inc     (in_sig & row_hit & lr_inc),
            .dec     (in_sig & row_hit & lr_dec),
            .ld      (do_quit),
            .ld_val  (cfg_q[r]),
            .q       (stg_q[r])
        );
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_TOP;
            level      <= 1'b0;
            cfg_q      <= '0;
            cfg_req    <= 1'b0;
            cfg_active <= 1'b0;
            cfg_err    <= 1'b0;
            idle_cnt   <= '0;
            ack_cnt    <= '0;
        end else begin
            cfg_err  <= 1'b0;
            idle_cnt <= (any_btn || !in_menu || do_quit) ? '0 : idle_cnt + 1'b1;
            ack_cnt  <= (state == S_COMMIT) ? ack_cnt + 1'b1 : '0;
            case (state)
                S_TOP: begin
                    if (p_conf && item_state(cnt_level1) != S_TOP) begin
                        state <= item_state(cnt_level1);
                        level <= 1'b1;
                    end
                end
                S_SIG, S_OSI, S_LOA: begin
                    if (do_quit) begin
                        state <= S_TOP;
                        level <= 1'b0;
                    end else if (commit_go) begin
                        state   <= S_COMMIT;
                        cfg_q   <= stg_q;
                        cfg_req <= 1'b1;
                    end
                end
                S_COMMIT: begin
                    if (cfg_ack) begin
                        state      <= S_SIG;
                        cfg_req    <= 1'b0;
                        cfg_active <= 1'b1;
                    end else if (ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
                        state   <= S_SIG;
                        cfg_req <= 1'b0;
                        cfg_err <= 1'b1;
                    end
                end
                default: state <= S_TOP;
            endcase
        end
    end

    assign stg_wave  = stg_q[ROW_WAVE];
    assign stg_amp   = stg_q[ROW_AMP];
    assign stg_fre   = stg_q[ROW_FRE];
    assign stg_phase = stg_q[ROW_PHASE];
    assign cfg_wave  = cfg_q[ROW_WAVE];
    assign cfg_amp   = cfg_q[ROW_AMP];
    assign cfg_fre   = cfg_q[ROW_FRE];
    assign cfg_phase = cfg_q[ROW_PHASE];

endmodule

// File: tb/tb_sig_menu_ctrl.sv
// tb/tb_sig_menu_ctrl.sv - directed and randomized checks of sig_menu_ctrl against a menu model
module tb_sig_menu_ctrl;

    localparam int IDLE = 100;
    localparam int ACKT = 16;

    localparam logic [5:0] B_Q = 6'b100000;
    localparam logic [5:0] B_C = 6'b010000;
    localparam logic [5:0] B_U = 6'b001000;
    localparam logic [5:0] B_D = 6'b000100;
    localparam logic [5:0] B_L = 6'b000010;
    localparam logic [5:0] B_R = 6'b000001;
    localparam logic [5:0] B_N = 6'b000000;

    logic clk_50M = 1'b0;
    logic rst_n = 1'b0;
    logic btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic btn_confirm = 1'b0, btn_quit = 1'b0, cfg_ack = 1'b0;
    logic [1:0] cnt_level1, stg_wave, stg_amp, stg_fre, stg_phase;
    logic [1:0] cfg_wave, cfg_amp, cfg_fre, cfg_phase;
    logic [2:0] sel_sig;
    logic       level, cfg_req, cfg_active, cfg_err;

    always #10 clk_50M = ~clk_50M;

    sig_menu_ctrl #(.IDLE_TIMEOUT(IDLE), .ACK_TIMEOUT(ACKT)) dut (
        .clk_50M(clk_50M), .rst_n(rst_n),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
        .btn_confirm(btn_confirm), .btn_quit(btn_quit), .cfg_ack(cfg_ack),
        .cnt_level1(cnt_level1), .level(level), .sel_sig(sel_sig),
        .stg_wave(stg_wave), .stg_amp(stg_amp), .stg_fre(stg_fre), .stg_phase(stg_phase),
        .cfg_wave(cfg_wave), .cfg_amp(cfg_amp), .cfg_fre(cfg_fre), .cfg_phase(cfg_phase),
        .cfg_req(cfg_req), .cfg_active(cfg_active), .cfg_err(cfg_err)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Model: mode 0 top, 1 sig, 2 osi, 3 loa, 4 waiting for ack; timers kept as edge timestamps
    int m_t, m_mode, m_item, m_sel, m_last, m_ct;
    int m_stg[4];
    int m_cfg[4];
    bit m_req, m_act, m_err;

    task automatic chk(input string tag, input logic [24:0] obs, input logic [24:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [24:0] dut_vec();
        return {cnt_level1, level, sel_sig, stg_wave, stg_amp, stg_fre, stg_phase,
                cfg_wave, cfg_amp, cfg_fre, cfg_phase, cfg_req, cfg_active, cfg_err};
    endfunction

    function automatic logic [24:0] mdl_vec();
        return {2'(m_item), (m_mode != 0), 3'(m_sel),
                2'(m_stg[0]), 2'(m_stg[1]), 2'(m_stg[2]), 2'(m_stg[3]),
                2'(m_cfg[0]), 2'(m_cfg[1]), 2'(m_cfg[2]), 2'(m_cfg[3]),
                m_req, m_act, m_err};
    endfunction

    task automatic model_reset();
        m_t = 0; m_mode = 0; m_item = 0; m_sel = 0; m_last = 0; m_ct = 0;
        for (int i = 0; i < 4; i++) begin m_stg[i] = 0; m_cfg[i] = 0; end
        m_req = 0; m_act = 0; m_err = 0;
    endtask

    task automatic model_step(input logic [5:0] b, input logic ack);
        int pre;
        bit in_menu, timeout;
        m_t++;
        pre = m_mode;
        m_err = 0;
        in_menu = (pre >= 1 && pre <= 3);
        timeout = in_menu && (m_t - m_last == IDLE);
        if (pre == 4) begin
            if (ack) begin
                m_req = 0; m_act = 1; m_mode = 1;
            end else if (m_t - m_ct == ACKT) begin
                m_req = 0; m_err = 1; m_mode = 1;
            end
        end else if (in_menu && (b[5] || timeout)) begin
            m_mode = 0; m_sel = 0;
            for (int i = 0; i < 4; i++) m_stg[i] = m_cfg[i];
        end else if (b[5]) begin
            m_mode = pre;
        end else if (b[4]) begin
            if (pre == 0) m_mode = m_item + 1;
            else if (pre == 1 && m_sel == 4) begin
                for (int i = 0; i < 4; i++) m_cfg[i] = m_stg[i];
                m_req = 1; m_mode = 4; m_ct = m_t;
            end
        end else if (b[3] || b[2]) begin
            if (pre == 1) m_sel = (m_sel + (b[3] ? 4 : 1)) % 5;
        end else if (b[1] || b[0]) begin
            if (pre == 0) m_item = (m_item + (b[1] ? 2 : 1)) % 3;
            else if (pre == 1 && m_sel < 4) m_stg[m_sel] = (m_stg[m_sel] + (b[1] ? 3 : 1)) % 4;
        end
        if ((|b) || pre == 0 || pre == 4) m_last = m_t;
    endtask

    task automatic tick(input logic [5:0] b, input logic ack);
        {btn_quit, btn_confirm, btn_up, btn_down, btn_left, btn_right} = b;
        cfg_ack = ack;
        model_step(b, ack);
        @(posedge clk_50M);
        #1;
        chk("cycle", dut_vec(), mdl_vec());
        {btn_quit, btn_confirm, btn_up, btn_down, btn_left, btn_right} = 6'b0;
        cfg_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_50M);
        #1;
        chk("reset", dut_vec(), 25'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // Top-level navigation with wrap
        tick(B_L, 1'b0);
        chk("top_left_wrap", 25'(cnt_level1), 25'd2);
        tick(B_R, 1'b0); tick(B_R, 1'b0);
        chk("top_right_wrap", 25'(cnt_level1), 25'd1);

        // Enter SIG from item 0, edit wave with wrap, move selection up with wrap
        tick(B_R, 1'b0); tick(B_R, 1'b0);
        chk("top_item0", 25'(cnt_level1), 25'd0);
        tick(B_C, 1'b0);
        chk("enter_sig_level", 25'(level), 25'd1);
        repeat (3) tick(B_R, 1'b0);
        chk("wave_3", 25'(stg_wave), 25'd3);
        tick(B_R, 1'b0);
        chk("wave_wrap_0", 25'(stg_wave), 25'd0);
        tick(B_U, 1'b0);
        chk("sel_wrap_4", 25'(sel_sig), 25'd4);

        // Commit with ack after 5 cycles
        tick(B_D, 1'b0); tick(B_D, 1'b0);
        tick(B_R, 1'b0); tick(B_R, 1'b0);
        chk("amp_2", 25'(stg_amp), 25'd2);
        tick(B_U, 1'b0); tick(B_U, 1'b0);
        tick(B_C, 1'b0);
        chk("commit_cfg_amp", 25'(cfg_amp), 25'd2);
        chk("commit_req", 25'(cfg_req), 25'd1);
        for (int k = 1; k <= 5; k++) begin
            tick(B_N, 1'(k == 5));
            if (k == 4) chk("req_held", 25'(cfg_req), 25'd1);
        end
        chk("ack_req_low", 25'(cfg_req), 25'd0);
        chk("ack_active", 25'(cfg_active), 25'd1);
        tick(B_D, 1'b0);
        chk("back_in_sig", 25'({level, sel_sig}), 25'({1'b1, 3'd0}));

        // Ack timeout from a fresh reset: err pulses 16 cycles after req rises
        do_reset();
        tick(B_C, 1'b0); tick(B_U, 1'b0); tick(B_C, 1'b0);
        chk("to_req_rise", 25'(cfg_req), 25'd1);
        for (int k = 1; k <= 16; k++) begin
            tick(B_N, 1'b0);
            if (k == 15) chk("to_no_err_yet", 25'({cfg_err, cfg_req}), 25'b01);
        end
        chk("to_err_pulse", 25'({cfg_err, cfg_req, cfg_active}), 25'b100);
        tick(B_N, 1'b0);
        chk("to_err_one_cycle", 25'(cfg_err), 25'd0);

        // Quit beats confirm on the apply row; edits are discarded
        tick(B_D, 1'b0); tick(B_R, 1'b0);
        chk("edit_wave_1", 25'(stg_wave), 25'd1);
        tick(B_U, 1'b0);
        tick(B_Q | B_C, 1'b0);
        chk("quit_wins", 25'({level, sel_sig, cfg_req, stg_wave}), 25'({1'b0, 3'd0, 1'b0, 2'd0}));

        // Idle timeout from OSI, then delayed by a button pulse
        tick(B_R, 1'b0);
        tick(B_C, 1'b0);
        chk("enter_osi", 25'(level), 25'd1);
        for (int k = 1; k <= 100; k++) begin
            tick(B_N, 1'b0);
            if (k == 99) chk("idle_99", 25'(level), 25'd1);
        end
        chk("idle_100", 25'({level, cnt_level1}), 25'({1'b0, 2'd1}));
        tick(B_C, 1'b0);
        for (int k = 1; k <= 150; k++) begin
            tick((k == 50) ? B_L : B_N, 1'b0);
            if (k == 100) chk("idle_delayed_100", 25'(level), 25'd1);
            if (k == 149) chk("idle_delayed_149", 25'(level), 25'd1);
        end
        chk("idle_delayed_150", 25'(level), 25'd0);

        // Random traffic at a busy and a sparse button rate
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [5:0] b;
            r = $urandom_range(0, 15);
            b = (r < 6) ? 6'(1 << r) : B_N;
            if ($urandom_range(0, 7) == 0) b = b | B_Q;
            if ($urandom_range(0, 7) == 0) b = b | B_C;
            tick(b, 1'($urandom_range(0, 5) == 0));
        end
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(0, 63);
            tick((r < 6) ? 6'(1 << r) : B_N, 1'($urandom_range(0, 19) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
